// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M iterative multiply/divide unit:
// funct3 encodings, FSM state type and counter sizing.
package muldiv_pkg;

    localparam int MD_XLEN  = 32;
    localparam int MD_CNT_W = $clog2(MD_XLEN);

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PREP = 3'd1,
        CALC = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } state_t;

    // MUL only keeps the low half, so it is treated as unsigned.
    function automatic logic f3_a_signed(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

    function automatic logic f3_b_signed(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// Issue/result bundle between the execute stage and the multiply/divide unit.
interface muldiv_if #(
    parameter int XLEN = 32
) ();
    logic            start;
    logic [2:0]      funct3;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            flush;
    logic            busy;
    logic            stall;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output start, funct3, op_a, op_b, flush,
        input  busy, stall, done, result
    );

    modport slave (
        input  start, funct3, op_a, op_b, flush,
        output busy, stall, done, result
    );
endinterface

// File: rtl/muldiv_step.sv
// One iteration of unsigned shift-add multiply or restoring divide on a
// 2*XLEN accumulator ({hi, lo}: product/multiplier or remainder/quotient).
module muldiv_step #(
    parameter int XLEN = 32
) (
    input  logic              is_div,
    input  logic [2*XLEN-1:0] acc,
    input  logic [XLEN-1:0]   operand,
    output logic [2*XLEN-1:0] acc_next
);

    logic [XLEN:0]   mul_sum;
    logic [XLEN:0]   rem_shift;
    logic [XLEN-1:0] rem_diff;

    always_comb begin
        mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, operand} : {(XLEN+1){1'b0}});
        rem_shift = acc[2*XLEN-1:XLEN-1];
        // The kept remainder is always below the divisor, so XLEN bits suffice.
        rem_diff  = rem_shift[XLEN-1:0] - operand;
        if (is_div) begin
            if (rem_shift >= {1'b0, operand}) begin
                acc_next = {rem_diff, acc[XLEN-2:0], 1'b1};
            end else begin
                acc_next = {rem_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0};
            end
        end else begin
            acc_next = {mul_sum, acc[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// RV32M execute-stage unit: one op at a time, XLEN iterations per multiply or
// divide, with divide-by-zero and signed overflow answered without iterating.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int XLEN = MD_XLEN
) (
    input  logic    clk,
    input  logic    rst,
    muldiv_if.slave bus
);

    localparam int              CNT_W    = $clog2(XLEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

    state_t            state_reg, state_next;
    logic [2:0]        f3_reg, f3_next;
    logic [XLEN-1:0]   a_reg, a_next;
    logic [XLEN-1:0]   b_reg, b_next;
    logic [2*XLEN-1:0] acc_reg, acc_next;
    logic [XLEN-1:0]   opnd_reg, opnd_next;
    logic              neg_res_reg, neg_res_next;
    logic              neg_rem_reg, neg_rem_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [XLEN-1:0]   result_reg, result_next;

    logic              busy;
    logic              done;
    logic              special;
    logic [XLEN-1:0]   special_result;
    logic              a_neg, b_neg;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic [2*XLEN-1:0] step_acc;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo, rem;
    logic [XLEN-1:0]   fix_result;

    muldiv_step #(.XLEN(XLEN)) u_step (
        .is_div   (f3_reg[2]),
        .acc      (acc_reg),
        .operand  (opnd_reg),
        .acc_next (step_acc)
    );

    // Special cases are decided straight from the issue bus so they finish in one cycle.
    always_comb begin
        logic b_zero;
        logic ovf;
        b_zero  = (bus.op_b == '0);
        ovf     = ((bus.funct3 == F3_DIV) || (bus.funct3 == F3_REM)) &&
                  (bus.op_a == INT_MIN) && (bus.op_b == '1);
        special = bus.funct3[2] && (b_zero || ovf);
        if (b_zero) begin
            special_result = bus.funct3[1] ? bus.op_a : '1;
        end else begin
            special_result = bus.funct3[1] ? '0 : INT_MIN;
        end
    end

    always_comb begin
        a_neg = f3_a_signed(f3_reg) && a_reg[XLEN-1];
        b_neg = f3_b_signed(f3_reg) && b_reg[XLEN-1];
        a_mag = a_neg ? -a_reg : a_reg;
        b_mag = b_neg ? -b_reg : b_reg;
    end

    // A zero divisor never reaches CALC, so the quotient sign needs no divisor check here.
    always_comb begin
        prod = neg_res_reg ? -acc_reg : acc_reg;
        quo  = neg_res_reg ? -acc_reg[XLEN-1:0] : acc_reg[XLEN-1:0];
        rem  = neg_rem_reg ? -acc_reg[2*XLEN-1:XLEN] : acc_reg[2*XLEN-1:XLEN];
        case (f3_reg)
            F3_MUL:                       fix_result = prod[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU: fix_result = prod[2*XLEN-1:XLEN];
            F3_DIV, F3_DIVU:              fix_result = quo;
            default:                      fix_result = rem;
        endcase
    end

    always_comb begin
        state_next   = state_reg;
        f3_next      = f3_reg;
        a_next       = a_reg;
        b_next       = b_reg;
        acc_next     = acc_reg;
        opnd_next    = opnd_reg;
        neg_res_next = neg_res_reg;
        neg_rem_next = neg_rem_reg;
        cnt_next     = cnt_reg;
        result_next  = result_reg;

        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    if (special) begin
                        result_next = special_result;
                        state_next  = DONE;
                    end else begin
                        f3_next    = bus.funct3;
                        a_next     = bus.op_a;
                        b_next     = bus.op_b;
                        state_next = PREP;
                    end
                end
            end
            PREP: begin
                neg_res_next = a_neg ^ b_neg;
                neg_rem_next = a_neg;
                if (f3_reg[2]) begin
                    acc_next  = {{XLEN{1'b0}}, a_mag};
                    opnd_next = b_mag;
                end else begin
                    acc_next  = {{XLEN{1'b0}}, b_mag};
                    opnd_next = a_mag;
                end
                cnt_next   = '0;
                state_next = CALC;
            end
            CALC: begin
                acc_next = step_acc;
                cnt_next = cnt_reg + 1'b1;
                if (cnt_reg == CNT_LAST) begin
                    cnt_next   = '0;
                    state_next = FIX;
                end
            end
            FIX: begin
                result_next = fix_result;
                state_next  = DONE;
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Flush beats everything, including a start that arrives in the same cycle.
        if (bus.flush) begin
            state_next  = IDLE;
            cnt_next    = '0;
            result_next = result_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            f3_reg      <= '0;
            a_reg       <= '0;
            b_reg       <= '0;
            acc_reg     <= '0;
            opnd_reg    <= '0;
            neg_res_reg <= 1'b0;
            neg_rem_reg <= 1'b0;
            cnt_reg     <= '0;
            result_reg  <= '0;
        end else begin
            state_reg   <= state_next;
            f3_reg      <= f3_next;
            a_reg       <= a_next;
            b_reg       <= b_next;
            acc_reg     <= acc_next;
            opnd_reg    <= opnd_next;
            neg_res_reg <= neg_res_next;
            neg_rem_reg <= neg_rem_next;
            cnt_reg     <= cnt_next;
            result_reg  <= result_next;
        end
    end

    assign busy       = (state_reg != IDLE);
    assign done       = (state_reg == DONE);
    assign bus.busy   = busy;
    assign bus.done   = done;
    assign bus.stall  = (bus.start && (state_reg == IDLE)) || (busy && !done);
    assign bus.result = result_reg;

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Iterative multi-cycle execution unit for the RV32M instructions: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU.
- Sits in the execute stage beside the single-cycle integer ALU.
- Accepts one operation at a time and stalls the pipeline while it runs.
- Multiplies by shift-add and divides by restoring division, one bit per cycle.
- Handles the RISC-V divide-by-zero and signed-overflow special cases without iterating.

Parameters:
XLEN, 32, operand and result width; the iteration count equals XLEN.

Ports:
clk  input  1  core clock, rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request; sampled only in IDLE
funct3  input  3  M-extension op select (000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU)
op_a  input  XLEN  rs1 value, sampled with start
op_b  input  XLEN  rs2 value, sampled with start
flush  input  1  abort the operation in flight (branch mispredict or trap)
busy  output  1  high in every state except IDLE
stall  output  1  pipeline hold; equals start&IDLE OR (busy AND NOT done)
done  output  1  one-cycle pulse; result valid in the same cycle
result  output  XLEN  operation result; held until the next accepted start

Behaviour:
- Reset (rst=1 at an edge): state=IDLE; busy, done and result clear to 0; internal registers clear to 0; counter=0. Reset has priority over all other inputs, including mid-operation.
- States:
  - IDLE: wait for start.
  - PREP: latch operand magnitudes and record result-sign flags.
  - CALC: XLEN iterations.
  - FIX: apply sign correction and select the high or low half.
  - DONE: assert done for exactly one cycle, then return to IDLE.
- IDLE, start=1, special case detected: go directly to DONE; done is high in the cycle after the start edge.
- IDLE, start=1, otherwise: go to PREP, latching funct3, op_a and op_b.
- Signedness of operands:
  - op_a is signed for MULH, MULHSU, DIV and REM.
  - op_b is signed for MULH, DIV and REM.
  - MUL uses the low half of the product, so signedness is irrelevant.
- Operand preparation: absolute values are taken for signed operands. The magnitude of -2^31 is 0x80000000 held as unsigned.
- CALC iteration timing: the counter runs 0..XLEN-1, one iteration per edge; after the iteration with counter=XLEN-1 the state moves to FIX.
- Multiply iteration: 2*XLEN-bit accumulator. If multiplier bit0=1, add the multiplicand into the upper half, then shift the accumulator right by 1 with carry-in.
- Divide iteration: shift {rem, quo} left by 1 and trial-subtract the divisor. If the difference is non-negative, keep it and set the quotient LSB to 1.
- FIX, product: negate the 64-bit product when exactly one signed operand was negative. MUL takes bits [31:0]; MULH, MULHSU and MULHU take bits [63:32].
- FIX, quotient and remainder: negate the quotient when the dividend and divisor signs differ and the divisor is non-zero. The remainder takes the sign of the dividend.
- Latency of a normal operation:
  - start edge E0, PREP at E1, CALC during E1..E33, FIX at E33, DONE at E34.
  - done is high in the cycle following E34, i.e. 34 cycles after start is sampled.
- Special cases (1-cycle latency):
  - DIV or DIVU with op_b=0: result=0xFFFFFFFF.
  - REM or REMU with op_b=0: result=op_a.
  - DIV with op_a=0x80000000 and op_b=0xFFFFFFFF: result=0x80000000.
  - REM with the same operands: result=0.
- start while busy is ignored; stall already holds the issuing instruction.
- flush: at the next edge the state goes to IDLE with no done pulse and result unchanged. flush and start together in IDLE: flush wins and the start is not accepted.
- flush in the same cycle as DONE: done is still high combinationally in that cycle; the pipeline discards it.
- result updates only when entering DONE.

Decomposition:
- Package muldiv_pkg holds:
  - the funct3 localparams (F3_MUL … F3_REMU);
  - the state enum IDLE/PREP/CALC/FIX/DONE;
  - the XLEN-derived counter width $clog2(XLEN).
- One natural sub-module, muldiv_step: combinational single-iteration logic (add-shift or subtract-shift) selected by an is_div input. It keeps the FSM in the top level clean.

Test Plan:
- MUL 7×6 (op_a=7, op_b=6, funct3=000) -> done exactly 34 cycles after start; result=42; busy=1 throughout; stall deasserts in the done cycle.
- MULH 0xFFFFFFFF×0xFFFFFFFF -> 0x00000000. MULHU with the same operands -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF×2 -> 0xFFFFFFFF.
- DIV -7/2 -> 0xFFFFFFFD (-3). REM -7/2 -> 0xFFFFFFFF (-1). DIVU 100/7 -> 14. REMU 100/7 -> 2.
- DIVU 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000. Each has done 1 cycle after start.
- Sequence of edge cases:
  - flush asserted 10 cycles into a DIV -> busy=0 next cycle, no done pulse, result unchanged.
  - A new MUL 3×3 started immediately afterwards -> 9.
  - A start pulsed while busy -> ignored.
- rst asserted mid-CALC -> all outputs 0 next edge; a following MULHU 0x80000000×2 -> 1.
